// File: rtl/apb3_fabric_n_if.sv
// apb3_fabric_n_if: upstream and downstream APB3 signals of the 1-to-N fabric
// Ports (signals): i_paddr/i_psel/i_penable/i_pwrite/i_pwdata upstream request,
// o_prdata/o_pready/o_pslverr upstream response, o_paddr/o_pwrite/o_pwdata/o_penable/o_psel
// shared downstream request, i_pready/i_prdata/i_pslverr per-slave responses.
// Modport slave is the fabric's view; modport master is the surrounding system's view.
interface apb3_fabric_n_if #(
    parameter int NUM_SLAVES = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]            i_paddr;
    logic                             i_psel;
    logic                             i_penable;
    logic                             i_pwrite;
    logic [DATA_WIDTH-1:0]            i_pwdata;
    logic [DATA_WIDTH-1:0]            o_prdata;
    logic                             o_pready;
    logic                             o_pslverr;
    logic [ADDR_WIDTH-1:0]            o_paddr;
    logic                             o_pwrite;
    logic [DATA_WIDTH-1:0]            o_pwdata;
    logic                             o_penable;
    logic [NUM_SLAVES-1:0]            o_psel;
    logic [NUM_SLAVES-1:0]            i_pready;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] i_prdata;
    logic [NUM_SLAVES-1:0]            i_pslverr;

    modport slave (
        input  i_paddr, i_psel, i_penable, i_pwrite, i_pwdata, i_pready, i_prdata, i_pslverr,
        output o_prdata, o_pready, o_pslverr, o_paddr, o_pwrite, o_pwdata, o_penable, o_psel
    );

    modport master (
        output i_paddr, i_psel, i_penable, i_pwrite, i_pwdata, i_pready, i_prdata, i_pslverr,
        input  o_prdata, o_pready, o_pslverr, o_paddr, o_pwrite, o_pwdata, o_penable, o_psel
    );
endinterface

// File: rtl/apb3_fabric_n.sv
// apb3_fabric_n: registered 1-to-N APB3 fabric with address decode, decode-error and timeout responses
// Ports: i_clk clock, i_rst async active-high reset, bus (slave modport) upstream/downstream APB3,
// o_decerr/o_timeout one-cycle error pulses, o_err_cnt saturating count of those pulses.
module apb3_fabric_n #(
    parameter int                              NUM_SLAVES     = 2,
    parameter int                              ADDR_WIDTH     = 32,
    parameter int                              DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDR     = {32'h0001_1000, 32'h0001_0000},
    parameter logic [ADDR_WIDTH-1:0]            ADDR_MASK     = 32'hFFFF_F000,
    parameter int                              TIMEOUT_CYCLES = 256,
    parameter logic [DATA_WIDTH-1:0]            ERR_DATA      = 32'hDEAD_BEEF,
    parameter int                              ERR_CNT_WIDTH  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    apb3_fabric_n_if.slave           bus,
    output logic                     o_decerr,
    output logic                     o_timeout,
    output logic [ERR_CNT_WIDTH-1:0] o_err_cnt
);
    localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
    // wide enough to hold TIMEOUT_CYCLES itself, and at least one bit when it is 0
    localparam int WW = $clog2(TIMEOUT_CYCLES + 2);

    typedef enum logic [2:0] {IDLE, DSETUP, DACCESS, DERR, RESP} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    paddr_q;
    logic                     pwrite_q;
    logic [DATA_WIDTH-1:0]    pwdata_q, prdata_q;
    logic [IW-1:0]            idx_q, idx_dec;
    logic [WW-1:0]            wd_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
    logic                     pslverr_q, decerr_q, timeout_q;
    logic                     hit_any, accept, done, expire, err_ev;

    // scan from the top so the lowest matching index is the one left standing
    always_comb begin
        hit_any = 1'b0;
        idx_dec = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--)
            if ((bus.i_paddr & ADDR_MASK) == BASE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit_any = 1'b1;
                idx_dec = IW'(i);
            end
    end

    assign accept = state_q == IDLE && bus.i_psel && !bus.i_penable;
    assign done   = state_q == DACCESS && bus.i_pready[idx_q];
    // a ready on the last allowed cycle takes precedence over the watchdog
    assign expire = state_q == DACCESS && !bus.i_pready[idx_q] && TIMEOUT_CYCLES != 0 &&
                    wd_q == WW'(TIMEOUT_CYCLES);
    assign err_ev = expire || state_q == DERR;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (hit_any ? DSETUP : DERR) : IDLE;
            DSETUP:  state_d = DACCESS;
            DACCESS: state_d = (done || expire) ? RESP : DACCESS;
            DERR:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_psel    = (state_q == DSETUP || state_q == DACCESS) ? NUM_SLAVES'(1) << idx_q : '0;
        bus.o_penable = state_q == DACCESS;
        bus.o_pready  = state_q == RESP;
        bus.o_prdata  = state_q == RESP ? prdata_q : '0;
        bus.o_pslverr = state_q == RESP && pslverr_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            idx_q     <= '0;
            wd_q      <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            decerr_q  <= 1'b0;
            timeout_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            if (accept) begin
                paddr_q  <= bus.i_paddr;
                pwrite_q <= bus.i_pwrite;
                pwdata_q <= bus.i_pwdata;
                idx_q    <= idx_dec;
            end
            // counter reads 1 during the first access cycle
            if (state_q == DSETUP) wd_q <= WW'(1);
            else if (state_q == DACCESS) wd_q <= wd_q + 1'b1;
            if (done) begin
                prdata_q  <= bus.i_prdata[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
                pslverr_q <= bus.i_pslverr[idx_q];
            end else if (err_ev) begin
                prdata_q  <= ERR_DATA;
                pslverr_q <= 1'b1;
            end
            decerr_q  <= state_q == DERR;
            timeout_q <= expire;
            if (err_ev && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign bus.o_paddr  = paddr_q;
    assign bus.o_pwrite = pwrite_q;
    assign bus.o_pwdata = pwdata_q;
    assign o_decerr     = decerr_q;
    assign o_timeout    = timeout_q;
    assign o_err_cnt    = err_cnt_q;
endmodule

// File: doc/apb3_fabric_n.md
Name: apb3_fabric_n

Overview:
- Parametrised 1-to-N APB3 fabric between the AXI-to-APB bridge and the peripheral slots (UART, user module, future slaves).
- Replaces the hard-wired two-slave fan-out and its glue logic.
- Registers each transfer and decodes its address against a per-slave base/mask map.
- Returns PSLVERR for unmapped addresses and aborts stalled slaves with a timeout watchdog. Exports error pulses and a saturating error counter.

Parameters:
- NUM_SLAVES, 2, number of downstream APB3 ports (1..16).
- ADDR_WIDTH, 32, PADDR width.
- DATA_WIDTH, 32, PWDATA/PRDATA width.
- BASE_ADDR, {32'h0001_1000, 32'h0001_0000}, packed NUM_SLAVES x ADDR_WIDTH; entry i is the base of slave i.
- ADDR_MASK, 32'hFFFF_F000, common decode mask (4K windows).
- TIMEOUT_CYCLES, 256, maximum downstream access-phase cycles; 0 disables the watchdog.
- ERR_DATA, 32'hDEAD_BEEF, PRDATA returned on decode error or timeout.
- ERR_CNT_WIDTH, 8, error counter width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_paddr  in  ADDR_WIDTH  upstream address
- i_psel  in  1  upstream select
- i_penable  in  1  upstream enable
- i_pwrite  in  1  upstream write
- i_pwdata  in  DATA_WIDTH  upstream write data
- o_prdata  out  DATA_WIDTH  upstream read data
- o_pready  out  1  upstream ready
- o_pslverr  out  1  upstream error
- o_paddr  out  ADDR_WIDTH  downstream address (full, not offset), shared by all slaves
- o_pwrite  out  1  downstream write, shared
- o_pwdata  out  DATA_WIDTH  downstream write data, shared
- o_penable  out  1  downstream enable, shared
- o_psel  out  NUM_SLAVES  one-hot downstream selects
- i_pready  in  NUM_SLAVES  per-slave ready
- i_prdata  in  NUM_SLAVES*DATA_WIDTH  per-slave read data, slave i at bits [i*DW +: DW]
- i_pslverr  in  NUM_SLAVES  per-slave error
- o_decerr  out  1  one-cycle pulse on decode error
- o_timeout  out  1  one-cycle pulse on watchdog abort
- o_err_cnt  out  ERR_CNT_WIDTH  saturating count of decerr + timeout events

Behaviour:
- Interface: one clock, i_clk; reset i_rst is asynchronous and active-high.
- Reset values: all outputs are 0. FSM is in IDLE, counters are cleared.
- Mid-transfer reset: o_psel and o_penable drop immediately (asynchronous); there is no upstream response.

Decode:
- hit[i] = ((i_paddr & ADDR_MASK) == BASE_ADDR[i]).
- On overlapping windows, the lowest index wins.
- Decode happens only in IDLE.

FSM:
- IDLE
  - On i_psel & !i_penable, latch paddr, pwrite, pwdata and the winning index.
  - If any hit, go to DSETUP; otherwise go to DERR.
  - o_pready = 0.
- DSETUP
  - o_psel[idx] = 1, o_penable = 0, watchdog counter cleared.
  - Next state: DACCESS.
- DACCESS
  - o_psel[idx] = 1, o_penable = 1; counter increments each cycle (first DACCESS cycle = 1).
  - If i_pready[idx]: capture i_prdata[idx] and i_pslverr[idx]; go to RESP.
  - Else if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES: drop o_psel/o_penable next cycle, capture ERR_DATA with slverr = 1, pulse o_timeout, go to RESP.
  - If pready and the timeout coincide, pready wins; no timeout is flagged.
- DERR
  - Capture ERR_DATA with slverr = 1, pulse o_decerr, go to RESP.
  - No o_psel bit is ever asserted for an unmapped address.
- RESP
  - o_pready = 1 for exactly one cycle, with the registered o_prdata and o_pslverr.
  - Next state: IDLE; o_prdata returns to 0.

Timing and counters:
- Latency, zero-wait slave: upstream setup at T0; downstream setup at T1; downstream access at T2 with pready; upstream o_pready at T3.
- Back-to-back transfers: the next upstream setup is accepted on the cycle after RESP.
- o_err_cnt increments on each o_decerr or o_timeout pulse and saturates at all-ones.
- Upstream signals are assumed stable through the transfer per APB3. Shared downstream outputs come from the latched copies, so they are stable from DSETUP to RESP.

Test Plan:
- Write 0x0001_0004 = 0x1234_5678, slave 0 zero-wait → o_psel = 2'b01 at T1, o_penable at T2, upstream o_pready = 1 and o_pslverr = 0 at T3; slave 0 sees o_pwdata = 0x1234_5678.
- Read 0x0001_1008, slave 1 with 3 wait states returning 0xCAFE_0001 → o_pready at T6, o_prdata = 0xCAFE_0001; o_psel[0] is never asserted.
- Read 0x0002_0000 (unmapped) → no o_psel bit; o_decerr pulse; o_pready at T2 with o_pslverr = 1, o_prdata = 0xDEAD_BEEF; o_err_cnt = 1.
- TIMEOUT_CYCLES = 4, slave 0 never ready → o_psel dropped after 4 access cycles, o_timeout pulse, upstream response pslverr = 1 with 0xDEAD_BEEF; a repeat gives o_err_cnt = 2. A separate case with pready arriving on the 4th cycle returns normal data and no timeout.
- Slave 1 returns i_pslverr = 1 → propagated as o_pslverr = 1 with the slave's data; o_err_cnt is unchanged.
- Assert i_rst during DACCESS → o_psel = 0, o_penable = 0, o_pready = 0 in the same cycle; after release, a new write completes normally. With ERR_CNT_WIDTH = 2 and 5 decode errors, o_err_cnt saturates at 3.
